// File: rtl/frcr_compare_irq_pkg.sv
// Shared definitions for FRCR compare channels: register map, bit positions
// and the compare-channel state encoding.
package frcr_compare_irq_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_COMPARE = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_ENABLE_BIT    = 0;
    localparam int CTRL_PERIODIC_BIT  = 1;
    localparam int STATUS_PENDING_BIT = 0;
    localparam int STATUS_OVERRUN_BIT = 1;

    typedef enum logic [1:0] {
        STATE_IDLE       = 2'b00,
        STATE_ARMED      = 2'b01,
        STATE_PEND       = 2'b10,
        STATE_PEND_ARMED = 2'b11
    } compareState_t;

    function automatic logic isArmed(input compareState_t s);
        return (s == STATE_ARMED) || (s == STATE_PEND_ARMED);
    endfunction

    function automatic logic isPending(input compareState_t s);
        return (s == STATE_PEND) || (s == STATE_PEND_ARMED);
    endfunction

    // Arming and pending are independent flags; this folds them back into one state.
    function automatic compareState_t packState(input logic pending, input logic armed);
        compareState_t s;
        case ({pending, armed})
            2'b00:   s = STATE_IDLE;
            2'b01:   s = STATE_ARMED;
            2'b10:   s = STATE_PEND;
            default: s = STATE_PEND_ARMED;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/frcr_compare_reach.sv
// Wrap-tolerant "counter has reached compare" test: the modular difference
// counter - compare lies in the lower half of the number space.
module frcr_compare_reach #(
    parameter int P_CNT_W = 64
) (
    input  logic [P_CNT_W-1:0] counter,
    input  logic [P_CNT_W-1:0] compare,
    output logic               reached
);

    localparam logic [P_CNT_W-1:0] HALF_RANGE = {1'b1, {(P_CNT_W-1){1'b0}}};

    assign reached = (counter - compare) < HALF_RANGE;

endmodule

// File: rtl/frcr_compare_irq.sv
// Compare/interrupt stage behind the FRCR counter: one-shot or periodic
// compare with a level interrupt held until acknowledged.
module frcr_compare_irq
    import frcr_compare_irq_pkg::*;
#(
    parameter int P_CNT_W = 64
) (
    input  logic               iCLOCK,
    input  logic               iRESET_SYNC,
    input  logic [P_CNT_W-1:0] iCOUNTER,
    input  logic               iCONF_WR_ENA,
    input  logic               iCONF_RD_ENA,
    input  logic [1:0]         iCONF_ADDR,
    input  logic [P_CNT_W-1:0] iCONF_DATA,
    output logic               oCONF_VALID,
    output logic [P_CNT_W-1:0] oCONF_DATA,
    output logic               oIRQ_VALID,
    input  logic               iIRQ_ACK
);

    compareState_t      state, stateNext;
    logic [P_CNT_W-1:0] compareReg, compareNext;
    logic [P_CNT_W-1:0] periodReg, periodNext;
    logic               periodicReg, periodicNext;
    logic               overrunReg, overrunNext;
    logic [P_CNT_W-1:0] readValue;
    logic               reached;
    logic               configWrite;
    logic               armedNext, pendingNext;

    frcr_compare_reach #(.P_CNT_W(P_CNT_W)) uReach (
        .counter (iCOUNTER),
        .compare (compareReg),
        .reached (reached)
    );

    // STATUS writes are dropped entirely, so they must not suppress a match either.
    assign configWrite = iCONF_WR_ENA && (iCONF_ADDR != ADDR_STATUS);

    always_comb begin
        readValue = '0;
        case (iCONF_ADDR)
            ADDR_CTRL: begin
                readValue[CTRL_ENABLE_BIT]   = isArmed(state);
                readValue[CTRL_PERIODIC_BIT] = periodicReg;
            end
            ADDR_COMPARE: readValue = compareReg;
            ADDR_PERIOD:  readValue = periodReg;
            default: begin
                readValue[STATUS_PENDING_BIT] = isPending(state);
                readValue[STATUS_OVERRUN_BIT] = overrunReg;
            end
        endcase
    end

    always_comb begin
        armedNext    = isArmed(state);
        pendingNext  = isPending(state);
        compareNext  = compareReg;
        periodNext   = periodReg;
        periodicNext = periodicReg;
        overrunNext  = overrunReg;

        if (iCONF_RD_ENA && (iCONF_ADDR == ADDR_STATUS)) begin
            overrunNext = 1'b0;
        end
        if (iIRQ_ACK) begin
            pendingNext = 1'b0;
        end

        if (iCONF_WR_ENA) begin
            case (iCONF_ADDR)
                ADDR_CTRL: begin
                    armedNext    = iCONF_DATA[CTRL_ENABLE_BIT];
                    periodicNext = iCONF_DATA[CTRL_PERIODIC_BIT];
                end
                ADDR_COMPARE: compareNext = iCONF_DATA;
                ADDR_PERIOD:  periodNext  = iCONF_DATA;
                default: ;
            endcase
        end

        // A configuration write in the same cycle discards the match.
        if (!configWrite && isArmed(state) && reached) begin
            if (periodicReg && (periodReg != '0)) begin
                compareNext = compareReg + periodReg;
            end else begin
                armedNext = 1'b0;
            end
            if (isPending(state) && !iIRQ_ACK) begin
                overrunNext = 1'b1;
            end
            pendingNext = 1'b1;
        end

        stateNext = packState(pendingNext, armedNext);
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state       <= STATE_IDLE;
            compareReg  <= '0;
            periodReg   <= '0;
            periodicReg <= 1'b0;
            overrunReg  <= 1'b0;
            oCONF_VALID <= 1'b0;
            oCONF_DATA  <= '0;
        end else begin
            state       <= stateNext;
            compareReg  <= compareNext;
            periodReg   <= periodNext;
            periodicReg <= periodicNext;
            overrunReg  <= overrunNext;
            oCONF_VALID <= iCONF_RD_ENA;
            if (iCONF_RD_ENA) begin
                oCONF_DATA <= readValue;
            end
        end
    end

    assign oIRQ_VALID = isPending(state);

endmodule

// File: tb/tb_frcr_compare_irq.sv
// Directed scenarios followed by random traffic, all checked cycle by cycle
// against a flag/arithmetic reference model of the compare channel.
module tb_frcr_compare_irq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] counter = '0;
    logic        confWrEna = 1'b0;
    logic        confRdEna = 1'b0;
    logic [1:0]  confAddr = '0;
    logic [63:0] confData = '0;
    logic        confValid;
    logic [63:0] confRdData;
    logic        irqValid;
    logic        irqAck = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;

    logic        mArmed = 0, mPending = 0, mPeriodic = 0, mOverrun = 0, mRdValid = 0;
    logic [63:0] mCompare = '0, mPeriod = '0, mRdData = '0;
    logic [63:0] cntVal = '0;
    logic [63:0] rdVal;
    logic [63:0] fireAt [3];
    int          fires;

    frcr_compare_irq #(.P_CNT_W(64)) dut (
        .iCLOCK       (clock),
        .iRESET_SYNC  (reset),
        .iCOUNTER     (counter),
        .iCONF_WR_ENA (confWrEna),
        .iCONF_RD_ENA (confRdEna),
        .iCONF_ADDR   (confAddr),
        .iCONF_DATA   (confData),
        .oCONF_VALID  (confValid),
        .oCONF_DATA   (confRdData),
        .oIRQ_VALID   (irqValid),
        .iIRQ_ACK     (irqAck)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle, advances the model across the edge, then checks outputs.
    task automatic applyStimulus(input logic [63:0] cnt, input logic wr, input logic rd,
                                 input logic [1:0] addr, input logic [63:0] data,
                                 input logic ack, input logic rst);
        logic        nArmed, nPending, nPeriodic, nOverrun, nRdValid;
        logic [63:0] nCompare, nPeriod, nRdData, regView;
        logic signed [63:0] distance;
        counter = cnt; confWrEna = wr; confRdEna = rd; confAddr = addr;
        confData = data; irqAck = ack; reset = rst;

        nArmed = mArmed; nPending = mPending; nPeriodic = mPeriodic; nOverrun = mOverrun;
        nCompare = mCompare; nPeriod = mPeriod; nRdValid = rd; nRdData = mRdData;
        if (rst) begin
            nArmed = 0; nPending = 0; nPeriodic = 0; nOverrun = 0;
            nCompare = 0; nPeriod = 0; nRdValid = 0; nRdData = 0;
        end else begin
            case (addr)
                2'd0:    regView = {62'd0, mPeriodic, mArmed};
                2'd1:    regView = mCompare;
                2'd2:    regView = mPeriod;
                default: regView = {62'd0, mOverrun, mPending};
            endcase
            if (rd) nRdData = regView;
            if (rd && addr == 2'd3) nOverrun = 0;
            if (ack) nPending = 0;
            if (wr && addr == 2'd0) begin nArmed = data[0]; nPeriodic = data[1]; end
            if (wr && addr == 2'd1) nCompare = data;
            if (wr && addr == 2'd2) nPeriod = data;
            distance = $signed(cnt - mCompare);
            if (!(wr && addr != 2'd3) && mArmed && distance >= 0) begin
                if (mPeriodic && mPeriod != 0) nCompare = mCompare + mPeriod;
                else nArmed = 0;
                if (mPending && !ack) nOverrun = 1;
                nPending = 1;
            end
        end

        @(posedge clock);
        #1;
        mArmed = nArmed; mPending = nPending; mPeriodic = nPeriodic; mOverrun = nOverrun;
        mCompare = nCompare; mPeriod = nPeriod; mRdValid = nRdValid; mRdData = nRdData;

        checkOutput("irq_valid", {63'd0, irqValid}, {63'd0, mPending});
        checkOutput("conf_valid", {63'd0, confValid}, {63'd0, mRdValid});
        if (mRdValid) checkOutput("conf_data", confRdData, mRdData);

        confWrEna = 0; confRdEna = 0; irqAck = 0; reset = 0;
    endtask

    task automatic tick();
        cntVal = cntVal + 1;
        applyStimulus(cntVal, 0, 0, 2'd0, '0, 0, 0);
    endtask

    task automatic ackTick();
        cntVal = cntVal + 1;
        applyStimulus(cntVal, 0, 0, 2'd0, '0, 1, 0);
    endtask

    task automatic writeReg(input logic [1:0] addr, input logic [63:0] data);
        applyStimulus(cntVal, 1, 0, addr, data, 0, 0);
    endtask

    task automatic readReg(input logic [1:0] addr, output logic [63:0] data);
        applyStimulus(cntVal, 0, 1, addr, '0, 0, 0);
        data = confRdData;
    endtask

    initial begin
        logic [1:0]  rAddr;
        logic [63:0] rData;
        for (int i = 0; i < 3; i++) fireAt[i] = '0;

        applyStimulus('0, 0, 0, 2'd0, '0, 0, 1);
        applyStimulus('0, 0, 0, 2'd0, '0, 0, 1);
        checkOutput("reset_irq", {63'd0, irqValid}, 64'd0);
        checkOutput("reset_conf_data", confRdData, 64'd0);

        // One-shot at 100
        cntVal = 64'd90;
        writeReg(2'd1, 64'd100);
        writeReg(2'd0, 64'd1);
        for (int i = 0; i < 9; i++) tick();
        checkOutput("oneshot_before", {63'd0, irqValid}, 64'd0);
        tick();
        checkOutput("oneshot_fire", {63'd0, irqValid}, 64'd1);
        readReg(2'd0, rdVal);
        checkOutput("oneshot_ctrl_cleared", rdVal, 64'd0);
        applyStimulus(cntVal, 0, 0, 2'd0, '0, 1, 0);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("oneshot_no_refire", {63'd0, irqValid}, 64'd0);

        // Periodic 50/70/90
        cntVal = 64'd40;
        writeReg(2'd2, 64'd20);
        writeReg(2'd1, 64'd50);
        writeReg(2'd0, 64'd3);
        fires = 0;
        for (int i = 0; i < 200 && fires < 3; i++) begin
            tick();
            if (irqValid) begin
                fireAt[fires] = cntVal;
                fires++;
                ackTick();
            end
        end
        checkOutput("periodic_fire_count", 64'(fires), 64'd3);
        checkOutput("periodic_fire0", fireAt[0], 64'd50);
        checkOutput("periodic_fire1", fireAt[1], 64'd70);
        checkOutput("periodic_fire2", fireAt[2], 64'd90);
        readReg(2'd1, rdVal);
        checkOutput("periodic_compare", rdVal, 64'd110);
        writeReg(2'd0, 64'd0);

        // Counter wrap
        cntVal = 64'hFFFF_FFFF_FFFF_FFFE;
        writeReg(2'd1, 64'd4);
        writeReg(2'd0, 64'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("wrap_irq", {63'd0, irqValid}, {63'd0, cntVal == 64'd4});
        end
        ackTick();

        // Overrun
        cntVal = 64'd200;
        writeReg(2'd2, 64'd5);
        writeReg(2'd1, 64'd210);
        writeReg(2'd0, 64'd3);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("overrun_first_fire", {63'd0, irqValid}, 64'd1);
        for (int i = 0; i < 12; i++) tick();
        readReg(2'd3, rdVal);
        checkOutput("overrun_status", rdVal, 64'd3);
        readReg(2'd3, rdVal);
        checkOutput("overrun_cleared", rdVal, 64'd1);
        applyStimulus(cntVal, 0, 0, 2'd0, '0, 1, 0);
        writeReg(2'd0, 64'd0);

        // Write in match cycle discards the match
        cntVal = 64'd300;
        writeReg(2'd1, 64'd305);
        writeReg(2'd0, 64'd1);
        for (int i = 0; i < 4; i++) tick();
        cntVal = 64'd305;
        applyStimulus(cntVal, 1, 0, 2'd1, 64'd400, 0, 0);
        checkOutput("write_wins", {63'd0, irqValid}, 64'd0);
        tick(); tick();
        checkOutput("write_wins_later", {63'd0, irqValid}, 64'd0);
        readReg(2'd0, rdVal);
        checkOutput("write_wins_armed", rdVal, 64'd1);
        writeReg(2'd0, 64'd0);

        // Ack coinciding with periodic re-match
        cntVal = 64'd500;
        writeReg(2'd2, 64'd3);
        writeReg(2'd1, 64'd505);
        writeReg(2'd0, 64'd3);
        for (int i = 0; i < 5; i++) tick();
        tick(); tick();
        ackTick();
        checkOutput("ack_rematch_irq", {63'd0, irqValid}, 64'd1);
        readReg(2'd3, rdVal);
        checkOutput("ack_rematch_status", rdVal, 64'd1);
        readReg(2'd1, rdVal);
        checkOutput("ack_rematch_compare", rdVal, 64'd511);

        // Reset while pending
        applyStimulus(cntVal, 0, 0, 2'd0, '0, 0, 1);
        checkOutput("reset_mid_irq", {63'd0, irqValid}, 64'd0);
        checkOutput("reset_mid_valid", {63'd0, confValid}, 64'd0);
        checkOutput("reset_mid_data", confRdData, 64'd0);
        for (int a = 0; a < 4; a++) begin
            readReg(2'(a), rdVal);
            checkOutput("reset_mid_reg", rdVal, 64'd0);
        end

        // Random traffic
        cntVal = {$urandom, $urandom};
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 3) cntVal = cntVal + {$urandom, $urandom};
            else cntVal = cntVal + 64'($urandom_range(0, 3));
            rAddr = 2'($urandom_range(0, 3));
            case (rAddr)
                2'd0:    rData = {$urandom, 30'd0, 2'($urandom_range(0, 3))};
                2'd1:    rData = cntVal + 64'($urandom_range(0, 60));
                2'd2:    rData = 64'($urandom_range(0, 12));
                default: rData = {$urandom, $urandom};
            endcase
            applyStimulus(cntVal, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                          rAddr, rData, $urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
